regfile_ctrl: RTL
=================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset, where 1 is reset asserted.
REQ-003 SHALL have port we, input, 1 bit: write enable, 1 = write requested.
REQ-004 SHALL have port waddr, input, 5 bits: write register address.
REQ-005 SHALL have port wdata, input, 32 bits: write data.
REQ-006 SHALL have port re1, input, 1 bit: read port 1 enable, driven by the decode stage.
REQ-007 SHALL have port raddr1, input, 5 bits: read port 1 address.
REQ-008 SHALL have port rdata1, output, 32 bits: read port 1 data.
REQ-009 SHALL have port re2, input, 1 bit: read port 2 enable.
REQ-010 SHALL have port raddr2, input, 5 bits: read port 2 address.
REQ-011 SHALL have port rdata2, output, 32 bits: read port 2 data.
REQ-012 SHALL have port ready, output, 1 bit: 1 = register file initialised and accepting traffic.

Function
REQ-013 SHALL hold 32 registers of 32 bits; register 0 SHALL read as 0x00000000 and SHALL never be written.
REQ-014 SHALL implement the storage array without reset; clearing SHALL be done by the init sequencer.
REQ-015 SHALL implement a state machine with two states, INIT and RUN.
REQ-016 SHALL, in INIT, on each rising edge write 0x00000000 to mem[cnt] and increment the 5-bit counter cnt.
REQ-017 SHALL, in INIT when cnt==31, perform the final clear and move to RUN; INIT therefore lasts exactly 31 rising edges after reset release.
REQ-018 SHALL drive ready=1 only in RUN; ready is registered and goes high on the 31st rising edge after reset release.
REQ-019 SHALL ignore we in INIT; an external write during INIT is dropped, not queued.
REQ-020 SHALL, in RUN, write wdata into mem[waddr] on the rising edge when we=1 and waddr!=0.
REQ-021 SHALL make reads combinational, with zero clock latency.
REQ-022 SHALL return 0x00000000 on rdataN when reN=0, when raddrN==0, or when the state is INIT; these rules are in priority order before any array access.
REQ-023 SHALL otherwise return mem[raddrN] on rdataN.
REQ-024 SHALL serve both read ports independently; the same address on both ports SHALL return identical data.
REQ-025 SHALL, for a write to waddr=0, have no effect on the array.
REQ-026 SHALL, for a read and a write to the same address in one cycle, follow REQ-033 and REQ-034.

Reset
REQ-027 SHALL, when rst=1, immediately and without waiting for clk set state to INIT, cnt to 1, and ready to 0.
REQ-028 SHALL, during rst=1, hold rdata1 and rdata2 at 0x00000000 and ignore writes.
REQ-029 SHALL, if reset asserts mid-INIT or in RUN, abandon the sequence in progress and restart the full 31-cycle clear after release.
REQ-030 SHALL sample reset deassertion synchronously with respect to clk, counting the first rising edge after release as INIT edge 1.

Configuration
REQ-031 SHALL use the macro REGFILE_BYPASS_EN to select write-to-read forwarding.
REQ-032 SHALL keep REQ-001 to REQ-030 unchanged in both configurations.
REQ-033 SHALL, when REGFILE_BYPASS_EN is defined, drive rdataN=wdata combinationally in RUN when reN=1, we=1 and raddrN==waddr!=0.
REQ-034 SHALL, when REGFILE_BYPASS_EN is undefined, drive rdataN with the old array value in the same case; the new value becomes visible from the next cycle.

Verification
REQ-035 SHALL cover init: pulse rst for 3 cycles -> ready=0 for 30 rising edges and =1 after the 31st; any read of r5 before that returns 0.
REQ-036 SHALL cover a basic write/read: in RUN write r5=0x1234ABCD, next cycle re1=1, raddr1=5 -> rdata1=0x1234ABCD; same read with re1=0 -> 0x00000000.
REQ-037 SHALL cover r0 protection: write r0=0xFFFFFFFF, then read r0 on both ports -> 0x00000000.
REQ-038 SHALL cover same-cycle read/write: r7=0x1 stored, then in one cycle we=1, waddr=7, wdata=0x2, re2=1, raddr2=7 -> rdata2=0x2 with REGFILE_BYPASS_EN, 0x1 without; 0x2 in both builds the following cycle.
REQ-039 SHALL cover reset during RUN: write r9=0xDEADBEEF, assert rst between clock edges -> ready falls with no clock edge; after release and 31 edges, reading r9 -> 0x00000000.
REQ-040 SHALL cover a write during INIT: we=1, waddr=3, wdata=0xA5A5A5A5 at INIT edge 10 -> r3 reads 0x00000000 after ready=1.

Source files
------------

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: 32x32 register file with a reset-triggered clear sequencer (r0 hardwired to zero).
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    output logic        ready
);
    typedef enum logic {INIT, RUN} state_t;
    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] mem [32];
    logic        fwd1, fwd2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= 5'd1;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end
    // Storage has no reset; the sequencer sweeps r1..r31 to zero after every reset release
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[cnt] <= 32'd0;
        else if (we && waddr != 5'd0)
            mem[waddr] <= wdata;
    end
`ifdef REGFILE_BYPASS_EN
    assign fwd1 = we && (waddr == raddr1);
    assign fwd2 = we && (waddr == raddr2);
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif
    always_comb begin
        rdata1 = (!re1 || raddr1 == 5'd0 || state != RUN) ? 32'd0 : fwd1 ? wdata : mem[raddr1];
        rdata2 = (!re2 || raddr2 == 5'd0 || state != RUN) ? 32'd0 : fwd2 ? wdata : mem[raddr2];
    end
endmodule
